// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of the 16-bit on-chip RAM: grant -> strobe -> ack -> release.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise master 0 has fixed priority.
module mem_arbiter #(
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_data_write,
    output logic [DATA_W-1:0] m0_data_read,
    input  logic              m0_uds,
    input  logic              m0_lds,
    input  logic              m0_rw,
    output logic              m0_ack,
    output logic              m0_err,

    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_data_write,
    output logic [DATA_W-1:0] m1_data_read,
    input  logic              m1_uds,
    input  logic              m1_lds,
    input  logic              m1_rw,
    output logic              m1_ack,
    output logic              m1_err,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_write,
    input  logic [DATA_W-1:0] mem_data_read,
    output logic              mem_uds,
    output logic              mem_lds,
    output logic              mem_rw,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RELEASE
    } state_t;

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

    state_t     state;
    logic       grant;     // master that owns the current (or most recent) access
    logic [7:0] counter;

    logic              req0;
    logic              req1;
    logic              pick;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              sel_uds;
    logic              sel_lds;
    logic              sel_rw;

    assign req0 = m0_uds | m0_lds;
    assign req1 = m1_uds | m1_lds;

`ifdef MEM_ARB_RR_EN
    // On a tie the master that did not win last time goes first; grant doubles as the pointer.
    assign pick = req1 & (~req0 | ~grant);
`else
    assign pick = req1 & ~req0;
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path can leave one unassigned (no latch).
        sel_addr = m0_addr;
        sel_data = m0_data_write;
        sel_uds  = m0_uds;
        sel_lds  = m0_lds;
        sel_rw   = m0_rw;
        if (pick) begin
            sel_addr = m1_addr;
            sel_data = m1_data_write;
            sel_uds  = m1_uds;
            sel_lds  = m1_lds;
            sel_rw   = m1_rw;
        end
    end

    // NOTE: all state and registered outputs use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            grant          <= 1'b1;
            counter        <= 8'd0;
            mem_addr       <= '0;
            mem_data_write <= '0;
            mem_uds        <= 1'b0;
            mem_lds        <= 1'b0;
            mem_rw         <= 1'b1;
            m0_ack         <= 1'b0;
            m0_err         <= 1'b0;
            m0_data_read   <= '0;
            m1_ack         <= 1'b0;
            m1_err         <= 1'b0;
            m1_data_read   <= '0;
        end else begin
            m0_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_ack <= 1'b0;
            m1_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant          <= pick;
                        counter        <= 8'd0;
                        mem_addr       <= sel_addr;
                        mem_data_write <= sel_data;
                        mem_uds        <= sel_uds;
                        mem_lds        <= sel_lds;
                        mem_rw         <= sel_rw;
                        state          <= ACCESS;
                    end
                end

                ACCESS: begin
                    // A RAM ack on the timeout cycle still wins: it is checked first.
                    if (mem_ack) begin
                        if (grant) begin
                            m1_ack <= 1'b1;
                            if (mem_rw) m1_data_read <= mem_data_read;
                        end else begin
                            m0_ack <= 1'b1;
                            if (mem_rw) m0_data_read <= mem_data_read;
                        end
                        mem_uds <= 1'b0;
                        mem_lds <= 1'b0;
                        state   <= RELEASE;
                    end else if (counter == LAST_COUNT) begin
                        if (grant) begin
                            m1_ack       <= 1'b1;
                            m1_err       <= 1'b1;
                            m1_data_read <= '1;
                        end else begin
                            m0_ack       <= 1'b1;
                            m0_err       <= 1'b1;
                            m0_data_read <= '1;
                        end
                        mem_uds <= 1'b0;
                        mem_lds <= 1'b0;
                        state   <= RELEASE;
                    end else begin
                        counter <= counter + 8'd1;
                    end
                end

                // Strobes stay low here so the RAM sees a clean edge before the next access.
                RELEASE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected acks, a monitor checks them.
// A small behavioural RAM (registered ack, no ack at addr >= 2**17) sits on the mem_* bus.
module tb_mem_arbiter;

    localparam int ADDR_W  = 18;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              reset_n;

    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [DATA_W-1:0] m0_data_write, m1_data_write;
    logic [DATA_W-1:0] m0_data_read, m1_data_read;
    logic              m0_uds, m0_lds, m0_rw, m0_ack, m0_err;
    logic              m1_uds, m1_lds, m1_rw, m1_ack, m1_err;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_write, mem_data_read;
    logic              mem_uds, mem_lds, mem_rw, mem_ack;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_addr(m0_addr), .m0_data_write(m0_data_write), .m0_data_read(m0_data_read),
        .m0_uds(m0_uds), .m0_lds(m0_lds), .m0_rw(m0_rw), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_addr(m1_addr), .m1_data_write(m1_data_write), .m1_data_read(m1_data_read),
        .m1_uds(m1_uds), .m1_lds(m1_lds), .m1_rw(m1_rw), .m1_ack(m1_ack), .m1_err(m1_err),
        .mem_addr(mem_addr), .mem_data_write(mem_data_write), .mem_data_read(mem_data_read),
        .mem_uds(mem_uds), .mem_lds(mem_lds), .mem_rw(mem_rw), .mem_ack(mem_ack)
    );

    // Behavioural RAM: 256 words aliased, writes on the first strobed edge, ack one cycle later.
    logic [15:0] ram [0:255];
    logic        ram_ack;
    logic        addr_ok;

    assign addr_ok       = (mem_addr < 18'h20000);
    assign mem_data_read = ram[mem_addr[7:0]];
    assign mem_ack       = ram_ack;

    initial begin
        ram_ack = 1'b0;
        for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
    end

    always @(posedge clk) begin
        ram_ack <= (mem_uds | mem_lds) && !ram_ack && addr_ok;
        if ((mem_uds | mem_lds) && !ram_ack && addr_ok && !mem_rw) begin
            if (mem_uds) ram[mem_addr[7:0]][15:8] <= mem_data_write[15:8];
            if (mem_lds) ram[mem_addr[7:0]][7:0]  <= mem_data_write[7:0];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          master;
        bit          err;
        bit          chk_data;
        logic [15:0] data;
        logic [15:0] mask;
    } exp_t;

    exp_t sb[$];

    task automatic expect_ack(input bit m, input bit err, input bit chk,
                              input logic [15:0] data, input logic [15:0] mask);
        exp_t e;
        e.master   = m;
        e.err      = err;
        e.chk_data = chk;
        e.data     = data;
        e.mask     = mask;
        sb.push_back(e);
    endtask

    // Monitor: every ack pulse is matched against the oldest expected completion.
    always @(negedge clk) begin
        if (reset_n && (m0_ack || m1_ack)) begin
            if (sb.size() == 0) begin
                check("spurious_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
            end else begin
                exp_t e;
                logic [15:0] rd;
                e = sb.pop_front();
                check("ack_master", {30'd0, m1_ack, m0_ack}, e.master ? 32'd2 : 32'd1);
                check("ack_err", 32'(e.master ? m1_err : m0_err), 32'(e.err));
                rd = e.master ? m1_data_read : m0_data_read;
                if (e.chk_data) check("read_data", 32'(rd & e.mask), 32'(e.data & e.mask));
            end
        end
    end

    // Strobe gap monitor: each new access must follow at least two strobe-low cycles.
    int low_run   = 0;
    bit seen_high = 1'b0;
    always @(negedge clk) begin
        if (mem_uds || mem_lds) begin
            if (seen_high && low_run > 0) check("strobe_gap_ge2", 32'(low_run >= 2), 32'd1);
            seen_high = 1'b1;
            low_run   = 0;
        end else begin
            low_run++;
        end
    end

    task automatic drive(input bit m, input logic [17:0] addr, input logic [15:0] wd,
                         input logic uds, input logic lds, input logic rw);
        if (m) begin
            m1_addr = addr; m1_data_write = wd; m1_uds = uds; m1_lds = lds; m1_rw = rw;
        end else begin
            m0_addr = addr; m0_data_write = wd; m0_uds = uds; m0_lds = lds; m0_rw = rw;
        end
    endtask

    // Called at a negedge; returns at the negedge where the master sees its ack.
    task automatic m_access(input bit m, input logic rw, input logic uds, input logic lds,
                            input logic [17:0] addr, input logic [15:0] wd,
                            input int exp_lat, input string name);
        int n;
        bit got;
        drive(m, addr, wd, uds, lds, rw);
        n   = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            got = m ? m1_ack : m0_ack;
        end
        check({name, "_ack_seen"}, 32'(got), 32'd1);
        if (got && exp_lat > 0) check({name, "_latency"}, n, exp_lat);
        drive(m, 18'd0, 16'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 18'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 18'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_strobes", {30'd0, mem_uds, mem_lds}, 32'd0);
        check("rst_mem_rw", 32'(mem_rw), 32'd1);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_data_write), 32'd0);
        check("rst_acks", {28'd0, m1_err, m1_ack, m0_err, m0_ack}, 32'd0);
        check("rst_rdata", {m1_data_read, m0_data_read}, 32'd0);
        reset_n = 1'b1;

        // 1: m0 full-word write then read back
        expect_ack(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        m_access(1'b0, 1'b0, 1'b1, 1'b1, 18'h00010, 16'hA55A, 3, "t1_wr");
        repeat (2) @(negedge clk);
        expect_ack(1'b0, 1'b0, 1'b1, 16'hA55A, 16'hFFFF);
        m_access(1'b0, 1'b1, 1'b1, 1'b1, 18'h00010, 16'h0000, 3, "t1_rd");
        repeat (2) @(negedge clk);

        // 2: m1 lower-lane write, read both lanes
        expect_ack(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        m_access(1'b1, 1'b0, 1'b0, 1'b1, 18'h00011, 16'hEE12, 3, "t2_wr");
        repeat (2) @(negedge clk);
        expect_ack(1'b1, 1'b0, 1'b1, 16'h0012, 16'h00FF);
        m_access(1'b1, 1'b1, 1'b1, 1'b1, 18'h00011, 16'h0000, 3, "t2_rd");
        repeat (2) @(negedge clk);

        // 3: simultaneous requests; last grant was m1, so both modes serve m0 first
        for (int i = 0; i < 4; i++) begin
            expect_ack(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
            expect_ack(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
            fork
                m_access(1'b0, 1'b0, 1'b1, 1'b1, 18'(32'h30 + i), 16'(32'h3000 + i), 3, "t3_m0");
                m_access(1'b1, 1'b0, 1'b1, 1'b1, 18'(32'h40 + i), 16'(32'h4000 + i), 7, "t3_m1");
            join
            repeat (2) @(negedge clk);
        end

        // 3b: tie right after an m0 grant separates fixed priority from round-robin
        expect_ack(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        m_access(1'b0, 1'b0, 1'b1, 1'b1, 18'h00050, 16'h5050, 3, "t3b_solo");
        repeat (2) @(negedge clk);
`ifdef MEM_ARB_RR_EN
        expect_ack(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        expect_ack(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        fork
            m_access(1'b0, 1'b0, 1'b1, 1'b1, 18'h00051, 16'h5151, 7, "t3b_m0");
            m_access(1'b1, 1'b0, 1'b1, 1'b1, 18'h00052, 16'h5252, 3, "t3b_m1");
        join
`else
        expect_ack(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        expect_ack(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        fork
            m_access(1'b0, 1'b0, 1'b1, 1'b1, 18'h00051, 16'h5151, 3, "t3b_m0");
            m_access(1'b1, 1'b0, 1'b1, 1'b1, 18'h00052, 16'h5252, 7, "t3b_m1");
        join
`endif
        repeat (2) @(negedge clk);

        // 4: unmapped address times out, then a normal read still works
        expect_ack(1'b0, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
        m_access(1'b0, 1'b1, 1'b1, 1'b1, 18'h20000, 16'h0000, TIMEOUT + 1, "t4_to");
        expect_ack(1'b0, 1'b0, 1'b1, 16'hA55A, 16'hFFFF);
        m_access(1'b0, 1'b1, 1'b1, 1'b1, 18'h00010, 16'h0000, 4, "t4_rd");
        repeat (2) @(negedge clk);

        // 5: back-to-back m1 writes (one per 4 cycles), then read them all back
        for (int i = 0; i < 4; i++) begin
            expect_ack(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
            m_access(1'b1, 1'b0, 1'b1, 1'b1, 18'(32'h20 + i), 16'(32'hC3A0 + i),
                     (i == 0) ? 3 : 4, "t5_wr");
        end
        for (int i = 0; i < 4; i++) begin
            expect_ack(1'b1, 1'b0, 1'b1, 16'(32'hC3A0 + i), 16'hFFFF);
            m_access(1'b1, 1'b1, 1'b1, 1'b1, 18'(32'h20 + i), 16'h0000, 4, "t5_rd");
        end
        repeat (2) @(negedge clk);

        // 6: reset during a hung access abandons it silently
        drive(1'b0, 18'h20000, 16'h0000, 1'b1, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        check("t6_in_access", {30'd0, mem_uds, mem_lds}, 32'd3);
        reset_n = 1'b0;
        @(negedge clk);
        check("t6_rst_strobes", {30'd0, mem_uds, mem_lds}, 32'd0);
        check("t6_rst_acks", {28'd0, m1_err, m1_ack, m0_err, m0_ack}, 32'd0);
        check("t6_rst_addr", 32'(mem_addr), 32'd0);
        drive(1'b0, 18'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        expect_ack(1'b0, 1'b0, 1'b1, 16'hA55A, 16'hFFFF);
        m_access(1'b0, 1'b1, 1'b1, 1'b1, 18'h00010, 16'h0000, 3, "t6_rd");

        repeat (4) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
